// File: rtl/ad_data_hsst_pkg.sv
// Shared constants, state encoding and control-word helpers for the HSST TX framer.
// SOF = {00, len, seq, K27.7}; EOF = {csum[15:0], seq, K29.7}.
package ad_data_hsst_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [7:0]  K27_7     = 8'hFB;
  localparam logic [7:0]  K29_7     = 8'hFD;

  localparam logic [31:0] IDLE_WORD = {8'h50, K28_5, 8'h50, K28_5};
  localparam logic [3:0]  IDLE_K    = 4'b0101;
  localparam logic [3:0]  CTRL_K    = 4'b0001;
  localparam logic [3:0]  DATA_K    = 4'b0000;

  localparam int CODE_LSB = 0;
  localparam int SEQ_LSB  = 8;
  localparam int LEN_LSB  = 16;
  localparam int CSUM_LSB = 16;

  typedef enum logic [1:0] {ST_IDLE, ST_SOF, ST_DATA, ST_EOF} state_t;

  function automatic logic [31:0] sof_word(input logic [7:0] len, input logic [7:0] seq);
    sof_word = '0;
    sof_word[CODE_LSB +: 8] = K27_7;
    sof_word[SEQ_LSB  +: 8] = seq;
    sof_word[LEN_LSB  +: 8] = len;
  endfunction

  function automatic logic [31:0] eof_word(input logic [15:0] csum, input logic [7:0] seq);
    eof_word = '0;
    eof_word[CODE_LSB +: 8]  = K29_7;
    eof_word[SEQ_LSB  +: 8]  = seq;
    eof_word[CSUM_LSB +: 16] = csum;
  endfunction

  function automatic logic [15:0] byte_sum(input logic [31:0] w);
    byte_sum = 16'(w[7:0]) + 16'(w[15:8]) + 16'(w[23:16]) + 16'(w[31:24]);
  endfunction

endpackage

// File: rtl/ad_data_hsst_tx_framer_if.sv
// FIFO read port and HSST TX lane bundle; master = framer, slave = FIFO/lane side.
interface ad_data_hsst_tx_framer_if;
  logic        tx_en;
  logic        fifo_rd_vld;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic [31:0] tx_data;
  logic [3:0]  tx_k;
  logic        frame_done;
  logic [7:0]  frame_seq;

  modport master (
    input  tx_en, fifo_rd_vld, fifo_rd_data,
    output fifo_rd_en, tx_data, tx_k, frame_done, frame_seq
  );

  modport slave (
    output tx_en, fifo_rd_vld, fifo_rd_data,
    input  fifo_rd_en, tx_data, tx_k, frame_done, frame_seq
  );
endinterface

// File: rtl/ad_data_hsst_tx_framer_byte_pack.sv
// 8-to-32 assembler: pops one FIFO byte per cycle, first byte lands in [7:0].
module ad_byte_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rd_vld,
  input  logic [7:0]  fifo_rd_data,
  input  logic        consume,
  input  logic        pop_inhibit,
  output logic [31:0] word,
  output logic        full,
  output logic        fifo_rd_en
);

  logic [2:0]  cnt;
  logic [1:0]  slot;

  assign full       = (cnt == 3'd4);
  assign fifo_rd_en = fifo_rd_vld & (~full | consume) & ~pop_inhibit;
  // a byte popped alongside a consumed word starts the next word
  assign slot       = consume ? 2'd0 : cnt[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (fifo_rd_en) begin
      word[{slot, 3'b000} +: 8] <= fifo_rd_data;
      cnt                       <= consume ? 3'd1 : cnt + 3'd1;
    end else if (consume) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/ad_data_hsst_tx_framer.sv
// Frames FIFO bytes into SOF / FRAME_WORDS data words / EOF on a 32-bit HSST lane,
// filling with IDLE_WORD whenever no word is ready.
module ad_data_hsst_tx_framer
  import ad_data_hsst_pkg::*;
#(
  parameter int          FRAME_WORDS = 64,
  parameter logic [31:0] IDLE_WORD   = ad_data_hsst_pkg::IDLE_WORD
) (
  input  logic                      clk,
  input  logic                      rst,
  ad_data_hsst_tx_framer_if.master  bus
);

  localparam logic [7:0] LEN = 8'(FRAME_WORDS);

  state_t      state, state_nxt;
  logic [7:0]  wcnt, wcnt_nxt;
  logic [15:0] csum, csum_nxt;
  logic [7:0]  seq, seq_nxt;
  logic [31:0] tx_nxt;
  logic [3:0]  k_nxt;
  logic        done_nxt;

  logic [31:0] word;
  logic        full, consume, pop_inhibit;

  assign consume     = (state == ST_DATA) & full;
  assign pop_inhibit = (state == ST_IDLE) & ~bus.tx_en;

  ad_byte_pack u_pack (
    .clk          (clk),
    .rst          (rst),
    .fifo_rd_vld  (bus.fifo_rd_vld),
    .fifo_rd_data (bus.fifo_rd_data),
    .consume      (consume),
    .pop_inhibit  (pop_inhibit),
    .word         (word),
    .full         (full),
    .fifo_rd_en   (bus.fifo_rd_en)
  );

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    csum_nxt  = csum;
    seq_nxt   = seq;
    tx_nxt    = IDLE_WORD;
    k_nxt     = IDLE_K;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: if (full && bus.tx_en) state_nxt = ST_SOF;
      ST_SOF: begin
        tx_nxt    = sof_word(LEN, seq);
        k_nxt     = CTRL_K;
        wcnt_nxt  = '0;
        csum_nxt  = '0;
        state_nxt = ST_DATA;
      end
      ST_DATA: if (full) begin
        tx_nxt   = word;
        k_nxt    = DATA_K;
        csum_nxt = csum + byte_sum(word);
        wcnt_nxt = wcnt + 8'd1;
        // post-increment compare: the last word goes straight to EOF
        if (wcnt_nxt == LEN) state_nxt = ST_EOF;
      end
      ST_EOF: begin
        tx_nxt    = eof_word(csum, seq);
        k_nxt     = CTRL_K;
        done_nxt  = 1'b1;
        seq_nxt   = seq + 8'd1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      wcnt           <= '0;
      csum           <= '0;
      seq            <= '0;
      bus.tx_data    <= IDLE_WORD;
      bus.tx_k       <= IDLE_K;
      bus.frame_done <= 1'b0;
    end else begin
      state          <= state_nxt;
      wcnt           <= wcnt_nxt;
      csum           <= csum_nxt;
      seq            <= seq_nxt;
      bus.tx_data    <= tx_nxt;
      bus.tx_k       <= k_nxt;
      bus.frame_done <= done_nxt;
    end
  end

  assign bus.frame_seq = seq;

endmodule

// File: tb/tb_ad_data_hsst_tx_framer.sv
// Directed bench: three framer instances (FRAME_WORDS 2/4/1) fed by counting-byte FIFO models.
module tb_ad_data_hsst_tx_framer;

  localparam logic [31:0] IDLE = 32'h50BC_50BC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ad_data_hsst_tx_framer_if ifa ();
  ad_data_hsst_tx_framer_if ifb ();
  ad_data_hsst_tx_framer_if ifc ();

  ad_data_hsst_tx_framer #(.FRAME_WORDS(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  ad_data_hsst_tx_framer #(.FRAME_WORDS(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  ad_data_hsst_tx_framer #(.FRAME_WORDS(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  // FIFO models: byte value = number of bytes popped so far + 1
  logic [7:0] ptr_a, ptr_b, ptr_c;
  always @(posedge clk or posedge rst)
    if (rst) ptr_a <= 8'd0; else if (ifa.fifo_rd_en) ptr_a <= ptr_a + 8'd1;
  always @(posedge clk or posedge rst)
    if (rst) ptr_b <= 8'd0; else if (ifb.fifo_rd_en) ptr_b <= ptr_b + 8'd1;
  always @(posedge clk or posedge rst)
    if (rst) ptr_c <= 8'd0; else if (ifc.fifo_rd_en) ptr_c <= ptr_c + 8'd1;
  assign ifa.fifo_rd_data = ptr_a + 8'd1;
  assign ifb.fifo_rd_data = ptr_b + 8'd1;
  assign ifc.fifo_rd_data = ptr_c + 8'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  int          sof_n, eof_n;
  logic [31:0] eof1, eof256, sof257;
  logic [7:0]  seq256;
  logic        done256;

  initial begin
    ifa.tx_en = 1'b0; ifa.fifo_rd_vld = 1'b1;
    ifb.tx_en = 1'b0; ifb.fifo_rd_vld = 1'b0;
    ifc.tx_en = 1'b0; ifc.fifo_rd_vld = 1'b0;
    sof_n = 0; eof_n = 0;
    eof1 = '0; eof256 = '0; sof257 = '0; seq256 = '0; done256 = 1'b0;

    // 1: asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("t1_data", ifa.tx_data, IDLE);
    chk("t1_k", ifa.tx_k, 4'b0101);
    chk("t1_seq", ifa.frame_seq, 8'h00);
    chk("t1_done", ifa.frame_done, 1'b0);
    chk("t1_rd_en", ifa.fifo_rd_en, 1'b0);
    @(posedge clk); #1 rst = 1'b0;

    // 2: FRAME_WORDS=2, continuous bytes
    ifa.tx_en = 1'b1; #1;
    chk("t2_pop_c0", ifa.fifo_rd_en, 1'b1);
    step(4);
    chk("t2_hold_full", ifa.fifo_rd_en, 1'b0);
    chk("t2_idle_c4", ifa.tx_data, IDLE);
    step(2);
    chk("t2_sof", ifa.tx_data, 32'h0002_00FB);
    chk("t2_sof_k", ifa.tx_k, 4'b0001);
    step(1);
    chk("t2_w1", ifa.tx_data, 32'h0403_0201);
    chk("t2_w1_k", ifa.tx_k, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_fill", ifa.tx_data, IDLE);
      chk("t2_fill_k", ifa.tx_k, 4'b0101);
    end
    step(1);
    chk("t2_w2", ifa.tx_data, 32'h0807_0605);
    chk("t2_done_early", ifa.frame_done, 1'b0);
    ifa.tx_en = 1'b0;
    step(1);
    chk("t2_eof", ifa.tx_data, 32'h0024_00FD);
    chk("t2_eof_k", ifa.tx_k, 4'b0001);
    chk("t2_done", ifa.frame_done, 1'b1);
    chk("t2_seq", ifa.frame_seq, 8'h01);
    step(1);
    chk("t2_done_once", ifa.frame_done, 1'b0);
    chk("t2_idle_after", ifa.tx_data, IDLE);
    ifa.fifo_rd_vld = 1'b0;

    // 3: same frame with a 10-cycle FIFO gap after byte 05
    do_reset();
    ifa.fifo_rd_vld = 1'b1; ifa.tx_en = 1'b1;
    step(6);
    chk("t3_sof", ifa.tx_data, 32'h0002_00FB);
    chk("t3_pop5", ifa.fifo_rd_en, 1'b1);
    step(1);
    chk("t3_w1", ifa.tx_data, 32'h0403_0201);
    ifa.fifo_rd_vld = 1'b0; #1;
    chk("t3_gap_rd_en", ifa.fifo_rd_en, 1'b0);
    for (int i = 1; i < 10; i++) begin
      step(1);
      chk("t3_gap_fill", ifa.tx_data, IDLE);
      chk("t3_gap_rd_en", ifa.fifo_rd_en, 1'b0);
    end
    step(1);
    ifa.fifo_rd_vld = 1'b1;
    chk("t3_fill", ifa.tx_data, IDLE);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t3_fill", ifa.tx_data, IDLE);
    end
    step(1);
    chk("t3_w2", ifa.tx_data, 32'h0807_0605);
    ifa.tx_en = 1'b0;
    step(1);
    chk("t3_eof", ifa.tx_data, 32'h0024_00FD);
    chk("t3_done", ifa.frame_done, 1'b1);
    chk("t3_seq", ifa.frame_seq, 8'h01);
    ifa.fifo_rd_vld = 1'b0;

    // 4: FRAME_WORDS=4, tx_en dropped after SOF
    step(1);
    ifb.fifo_rd_vld = 1'b1; ifb.tx_en = 1'b1;
    step(6);
    chk("t4_sof", ifb.tx_data, 32'h0004_00FB);
    ifb.tx_en = 1'b0;
    step(1);
    chk("t4_w1", ifb.tx_data, 32'h0403_0201);
    step(4);
    chk("t4_w2", ifb.tx_data, 32'h0807_0605);
    step(4);
    chk("t4_w3", ifb.tx_data, 32'h0C0B_0A09);
    step(4);
    chk("t4_w4", ifb.tx_data, 32'h100F_0E0D);
    step(1);
    chk("t4_eof", ifb.tx_data, 32'h0088_00FD);
    chk("t4_done", ifb.frame_done, 1'b1);
    chk("t4_seq", ifb.frame_seq, 8'h01);
    chk("t4_rd_en_off", ifb.fifo_rd_en, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("t4_idle", ifb.tx_data, IDLE);
      chk("t4_rd_en_off", ifb.fifo_rd_en, 1'b0);
    end

    // 6: reset during DATA after one of four words (bytes 17,18 already held)
    step(1);
    ifb.tx_en = 1'b1;
    step(4);
    chk("t6_sof_pre", ifb.tx_data, 32'h0004_01FB);
    step(1);
    chk("t6_w1_pre", ifb.tx_data, 32'h1413_1211);
    step(1);
    rst = 1'b1; #1;
    chk("t6_rst_data", ifb.tx_data, IDLE);
    chk("t6_rst_k", ifb.tx_k, 4'b0101);
    chk("t6_rst_seq", ifb.frame_seq, 8'h00);
    chk("t6_rst_done", ifb.frame_done, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    step(6);
    chk("t6_sof", ifb.tx_data, 32'h0004_00FB);
    step(1);
    chk("t6_w1", ifb.tx_data, 32'h0403_0201);
    ifb.tx_en = 1'b0;
    step(13);
    chk("t6_eof", ifb.tx_data, 32'h0088_00FD);
    chk("t6_done", ifb.frame_done, 1'b1);
    ifb.fifo_rd_vld = 1'b0;

    // 5: FRAME_WORDS=1, 257 frames for sequence wrap
    step(1);
    ifc.fifo_rd_vld = 1'b1; ifc.tx_en = 1'b1;
    for (int i = 0; i < 4000 && sof_n < 257; i++) begin
      step(1);
      if (ifc.tx_k === 4'b0001 && ifc.tx_data[7:0] === 8'hFB) begin
        sof_n++;
        if (sof_n == 257) sof257 = ifc.tx_data;
      end
      if (ifc.tx_k === 4'b0001 && ifc.tx_data[7:0] === 8'hFD) begin
        eof_n++;
        if (eof_n == 1) eof1 = ifc.tx_data;
        if (eof_n == 256) begin
          eof256  = ifc.tx_data;
          seq256  = ifc.frame_seq;
          done256 = ifc.frame_done;
        end
      end
    end
    chk("t5_sof_count", sof_n, 257);
    chk("t5_eof1", eof1, 32'h000A_00FD);
    chk("t5_eof256", eof256, 32'h02FA_FFFD);
    chk("t5_seq_wrap", seq256, 8'h00);
    chk("t5_done256", done256, 1'b1);
    chk("t5_sof257", sof257, 32'h0001_00FB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
